// File: rtl/draw_sky_objects.sv
// draw_sky_objects: night-sky sprite address generator for the background layer.
// Tracks a once-per-night moon phase and a frame-driven star twinkle sprite, and
// maps the current write pixel to a registered hit flag, object ID and ROM address.
// Ports:
//   Clk         pixel-domain clock
//   Reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per frame (start of vblank)
//   isnight     night mode level
//   WriteX/Y    current pixel coordinates
//   sky_on      pixel hits the moon or a star (registered)
//   is_moon     hit object is the moon (registered)
//   star_id     index of the star hit, 0 otherwise (registered)
//   address     18-bit sprite ROM address, 0 on a miss (registered)
//   moon_phase  current moon phase index
module draw_sky_objects #(
    parameter int unsigned NUM_STARS      = 4,
    parameter int unsigned TWINKLE_FRAMES = 10,
    parameter int unsigned MOON_X         = 0,
    parameter int unsigned MOON_Y         = 80,
    parameter logic [20*NUM_STARS-1:0] STAR_XY =
        {10'd420, 10'd50, 10'd300, 10'd30, 10'd200, 10'd60, 10'd100, 10'd20}
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        isnight,
    input  logic [9:0]  WriteX,
    input  logic [9:0]  WriteY,
    output logic        sky_on,
    output logic        is_moon,
    output logic [((NUM_STARS > 1) ? $clog2(NUM_STARS) : 1)-1:0] star_id,
    output logic [17:0] address,
    output logic [2:0]  moon_phase
);

    localparam int unsigned SID_W = (NUM_STARS > 1) ? $clog2(NUM_STARS) : 1;
    localparam int unsigned TW_W  = (TWINKLE_FRAMES > 1) ? $clog2(TWINKLE_FRAMES) : 1;

    typedef enum logic [2:0] {
        PH_FULL = 3'd0,
        PH_L1   = 3'd1,
        PH_L2   = 3'd2,
        PH_L3   = 3'd3,
        PH_R1   = 3'd4,
        PH_R2   = 3'd5,
        PH_R3   = 3'd6
    } phase_t;

    phase_t            phase, phase_nxt;
    logic              night_prev;
    logic [TW_W-1:0]   tw_cnt;
    logic [1:0]        g;

    // Phase, night edge detector and twinkle counter only move on frame_tick
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase      <= PH_FULL;
            night_prev <= 1'b0;
            tw_cnt     <= '0;
            g          <= 2'd0;
        end else if (frame_tick) begin
            phase      <= phase_nxt;
            night_prev <= isnight;
            if (tw_cnt == TW_W'(TWINKLE_FRAMES - 1)) begin
                tw_cnt <= '0;
                g      <= (g == 2'd2) ? 2'd0 : g + 2'd1;
            end else begin
                tw_cnt <= tw_cnt + TW_W'(1);
            end
        end
    end

    // Moon phase order: full, waning right, new, waxing left, full
    always_comb begin
        phase_nxt = phase;
        if (frame_tick && isnight && !night_prev) begin
            case (phase)
                PH_FULL: phase_nxt = PH_R1;
                PH_R1:   phase_nxt = PH_R2;
                PH_R2:   phase_nxt = PH_R3;
                PH_R3:   phase_nxt = PH_L3;
                PH_L3:   phase_nxt = PH_L2;
                PH_L2:   phase_nxt = PH_L1;
                PH_L1:   phase_nxt = PH_FULL;
                default: phase_nxt = PH_FULL;
            endcase
        end
    end

    logic [10:0] wx, wy;
    logic [10:0] mx0, my0;
    logic [6:0]  mw;
    logic [17:0] mbase;
    logic        moon_hit;
    logic [10:0] sx, sy;
    logic [4:0]  sh;
    logic [17:0] sbase;
    logic        star_hit;
    logic [SID_W-1:0] sid;
    logic [17:0] saddr;
    logic        hit_c, moon_c;
    logic [SID_W-1:0] sid_c;
    logic [17:0] addr_c;

    // Moon geometry for the current phase
    always_comb begin
        mx0   = 11'(MOON_X);
        mw    = 7'd40;
        mbase = 18'd142615;
        case (phase)
            PH_FULL: begin mw = 7'd80; mbase = 18'd142615; end
            PH_L1:   mbase = 18'd149015;
            PH_L2:   mbase = 18'd152215;
            PH_L3:   mbase = 18'd155415;
            PH_R1:   begin mx0 = 11'(MOON_X + 40); mbase = 18'd158615; end
            PH_R2:   begin mx0 = 11'(MOON_X + 40); mbase = 18'd161815; end
            PH_R3:   begin mx0 = 11'(MOON_X + 40); mbase = 18'd165015; end
            default: begin mw = 7'd80; mbase = 18'd142615; end
        endcase
    end

    assign wx  = {1'b0, WriteX};
    assign wy  = {1'b0, WriteY};
    assign my0 = 11'(MOON_Y);
    assign moon_hit = (wx >= mx0) && (wx < mx0 + 11'(mw)) &&
                      (wy >= my0) && (wy < my0 + 11'd80);

    // Star scan runs high to low so the lowest matching index is left standing
    always_comb begin
        star_hit = 1'b0;
        sid      = '0;
        saddr    = '0;
        sx       = '0;
        sy       = '0;
        sh       = 5'd17;
        sbase    = 18'd224411;
        for (int i = int'(NUM_STARS) - 1; i >= 0; i--) begin
            sx = {1'b0, STAR_XY[20*i+10 +: 10]};
            sy = {1'b0, STAR_XY[20*i +: 10]};
            case (2'((int'(g) + i) % 3))
                2'd0:    begin sbase = 18'd224411; sh = 5'd17; end
                2'd1:    begin sbase = 18'd224717; sh = 5'd19; end
                default: begin sbase = 18'd225059; sh = 5'd18; end
            endcase
            if ((wx >= sx) && (wx < sx + 11'd18) &&
                (wy >= sy) && (wy < sy + 11'(sh))) begin
                star_hit = 1'b1;
                sid      = SID_W'(i);
                saddr    = sbase + 18'(wy - sy) * 18'd18 + 18'(wx - sx);
            end
        end
    end

    // Moon beats stars; daytime forces a miss
    always_comb begin
        hit_c  = 1'b0;
        moon_c = 1'b0;
        sid_c  = '0;
        addr_c = '0;
        if (isnight) begin
            if (moon_hit) begin
                hit_c  = 1'b1;
                moon_c = 1'b1;
                addr_c = mbase + 18'(wy - my0) * 18'(mw) + 18'(wx - mx0);
            end else if (star_hit) begin
                hit_c  = 1'b1;
                sid_c  = sid;
                addr_c = saddr;
            end
        end
    end

    // Registered lookup result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sky_on  <= 1'b0;
            is_moon <= 1'b0;
            star_id <= '0;
            address <= '0;
        end else begin
            sky_on  <= hit_c;
            is_moon <= moon_c;
            star_id <= sid_c;
            address <= addr_c;
        end
    end

    assign moon_phase = phase;

endmodule

// File: tb/tb_draw_sky_objects.sv
// tb_draw_sky_objects: directed plus randomized bench for draw_sky_objects,
// compared against a behavioural model of the sky (night count, frame count).
module tb_draw_sky_objects;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        isnight = 1'b0;
    logic [9:0]  WriteX = '0;
    logic [9:0]  WriteY = '0;
    logic        sky_on;
    logic        is_moon;
    logic [1:0]  star_id;
    logic [17:0] address;
    logic [2:0]  moon_phase;

    draw_sky_objects dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .isnight(isnight),
        .WriteX(WriteX), .WriteY(WriteY), .sky_on(sky_on), .is_moon(is_moon),
        .star_id(star_id), .address(address), .moon_phase(moon_phase)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state: phase position in the night cycle, frame counts
    int SEQ[7]   = '{0, 4, 5, 6, 3, 2, 1};
    int MBASE[7] = '{142615, 149015, 152215, 155415, 158615, 161815, 165015};
    int SBASE[3] = '{224411, 224717, 225059};
    int SH[3]    = '{17, 19, 18};
    int SX[4]    = '{100, 200, 300, 420};
    int SY[4]    = '{20, 60, 30, 50};
    int m_idx = 0, m_nprev = 0, m_tw = 0, m_g = 0;

    function automatic void model_lookup(input int x, input int y, input int night,
                                         output int on, output int moon,
                                         output int id, output int addr);
        int p, x0, w;
        on = 0; moon = 0; id = 0; addr = 0;
        if (night == 0) return;
        p  = SEQ[m_idx];
        x0 = (p >= 4) ? 40 : 0;
        w  = (p == 0) ? 80 : 40;
        if (x >= x0 && x < x0 + w && y >= 80 && y < 160) begin
            on = 1; moon = 1;
            addr = (MBASE[p] + (y - 80) * w + (x - x0)) % (1 << 18);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            int s;
            s = (m_g + i) % 3;
            if (x >= SX[i] && x < SX[i] + 18 && y >= SY[i] && y < SY[i] + SH[s]) begin
                on = 1; id = i;
                addr = (SBASE[s] + (y - SY[i]) * 18 + (x - SX[i])) % (1 << 18);
                return;
            end
        end
    endfunction

    // One clock: drive inputs, predict from pre-edge state, check after the edge
    task automatic step(input bit rst, input bit tick, input bit night, input int x, input int y);
        int e_on, e_moon, e_id, e_addr;
        @(negedge Clk);
        Reset = rst; frame_tick = tick; isnight = night;
        WriteX = 10'(x); WriteY = 10'(y);
        if (rst) begin
            e_on = 0; e_moon = 0; e_id = 0; e_addr = 0;
            m_idx = 0; m_nprev = 0; m_tw = 0; m_g = 0;
        end else begin
            model_lookup(x, y, int'(night), e_on, e_moon, e_id, e_addr);
            if (tick) begin
                if (night && m_nprev == 0) m_idx = (m_idx + 1) % 7;
                m_nprev = int'(night);
                m_tw++;
                if (m_tw == 10) begin
                    m_tw = 0;
                    m_g = (m_g + 1) % 3;
                end
            end
        end
        @(posedge Clk);
        #1;
        check("sky_on", 32'(sky_on), 32'(e_on));
        check("is_moon", 32'(is_moon), 32'(e_moon));
        check("star_id", 32'(star_id), 32'(e_id));
        check("address", 32'(address), 32'(e_addr));
        check("moon_phase", 32'(moon_phase), 32'(SEQ[m_idx]));
    endtask

    initial begin
        bit nt;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Full moon lookup straight out of reset
        step(0, 0, 1, 10, 85);
        check("tp1_addr", 32'(address), 32'd143025);

        // First night start moves to right-half phase
        step(0, 1, 1, 0, 0);
        check("tp2_phase", 32'(moon_phase), 32'd4);
        step(0, 0, 1, 45, 80);
        check("tp2_addr", 32'(address), 32'd158620);
        step(0, 0, 1, 10, 85);
        check("tp2_miss", 32'(sky_on), 32'd0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
        check("tp2_hold", 32'(moon_phase), 32'd4);

        // Remaining night starts walk the whole cycle
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 1, 0, 0);
        end
        check("tp3_wrap", 32'(moon_phase), 32'd0);

        // Star 0 with sprite 0, then sprite 1 after one twinkle period
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 101, 21);
        check("tp4_addr_g0", 32'(address), 32'd224430);
        step(0, 0, 1, 100, 37);
        check("tp4_miss_g0", 32'(sky_on), 32'd0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 101, 21);
        check("tp4_addr_g1", 32'(address), 32'd224736);
        step(0, 0, 1, 100, 37);
        check("tp4_hit_g1", 32'(sky_on), 32'd1);

        // Daytime miss and reset mid-frame
        step(0, 0, 0, 10, 85);
        check("tp5_day_addr", 32'(address), 32'd0);
        step(0, 0, 1, 10, 85);
        step(1, 0, 1, 10, 85);
        check("tp5_rst_on", 32'(sky_on), 32'd0);

        // Tick coincident with lookup uses the old phase
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 10, 85);
        check("tp6_old_phase", 32'(address), 32'd143025);
        step(0, 0, 1, 45, 80);
        check("tp6_new_phase", 32'(address), 32'd158620);

        // Randomized traffic concentrated around the objects
        nt = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            int x, y;
            bit r, t;
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) nt = ~nt;
            if ($urandom_range(0, 9) < 7) begin
                x = $urandom_range(0, 460);
                y = $urandom_range(0, 170);
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            step(r, t, nt, x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_sky_objects.md
Name: draw_sky_objects

Overview:
Night-sky sprite address generator for the background layer. It is the parametrised successor of the single-moon, two-star drawer. It supports NUM_STARS independently twinkling stars and a deterministic moon-phase cycle that advances once per night. Given the current write pixel, it returns a registered hit flag, an object ID and an 18-bit sprite-ROM address for the palette/compositor stage.

Parameters:
NUM_STARS, 4, number of star instances (1..8)
TWINKLE_FRAMES, 10, frame_ticks per twinkle sprite step (>=1)
MOON_X, 0, moon left edge (pixels)
MOON_Y, 80, moon top edge
STAR_XY, {(100,20),(200,60),(300,30),(420,50)}, packed 20 bits per star: X in [19:10], Y in [9:0]; star i occupies bits [20i+19:20i]

Ports:
Clk  in  1  pixel-domain clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
isnight  in  1  night mode level
WriteX  in  10  current pixel X
WriteY  in  10  current pixel Y
sky_on  out  1  pixel hits a sky object (registered)
is_moon  out  1  hit object is the moon
star_id  out  $clog2(NUM_STARS) (min 1)  index of the star hit; 0 when not a star hit
address  out  18  sprite ROM address (registered)
moon_phase  out  3  current phase index

Behaviour:
- ROM bases: phase 0 Full = 142615 (80x80); 1 Left1 = 149015; 2 Left2 = 152215; 3 Left3 = 155415; 4 Right1 = 158615; 5 Right2 = 161815; 6 Right3 = 165015. Phases 1..6 are 40x80.
- Star sprite bases: s0 = 224411 (18x17); s1 = 224717 (18x19); s2 = 225059 (18x18).
- Moon placement:
  - Full: X = MOON_X, width 80.
  - Left phases: X = MOON_X, width 40.
  - Right phases: X = MOON_X+40, width 40.
  - All phases: Y = MOON_Y, height 80.
- Phase sequence: 0 -> 4 -> 5 -> 6 -> 3 -> 2 -> 1 -> 0 (wraps).
- Phase advance:
  - night_prev updates only on frame_tick.
  - Phase advances on frame_tick when isnight=1 and night_prev=0.
  - Only one advance per night, however long the night lasts.
- Twinkle counter: tw_cnt counts 0..TWINKLE_FRAMES-1 on each frame_tick. On wrap, global sprite g advances 0 -> 1 -> 2 -> 0. It runs regardless of isnight.
- Star sprite: star i uses sprite (g+i) mod 3; its height follows that sprite (17/19/18 rows).
- Hit test:
  - Moon has priority over stars; a lower star index beats a higher one.
  - Bounds are half-open: loc <= W < loc+size on both axes.
  - isnight=0 forces a miss.
- Address: base + DY*width + DX, with DX = WriteX-locX and DY = WriteY-locY. Computed unsigned and truncated to 18 bits. On a miss, address = 0.
- Latency: exactly 1 cycle. Outputs at edge n+1 reflect WriteX/WriteY/isnight sampled at edge n and the phase/g state before any update at edge n.
- Same-cycle frame_tick and lookup: the lookup uses the old phase/g. New values apply from the next cycle.
- Reset values:
  - Outputs: sky_on=0, is_moon=0, star_id=0, address=0, moon_phase=0.
  - Internal state: tw_cnt=0, g=0, night_prev=0.
  - Reset mid-night: next frame_tick with isnight=1 is treated as a new night, so the phase advances 0 -> 4.
- Miss: star_id=0, is_moon=0.

Test Plan:
1. Reset, isnight=1 with no frame_tick, pixel (10,85) -> next cycle: sky_on=1, is_moon=1, address = 142615+5*80+10 = 143025.
2. One frame_tick with isnight=1 (night start) -> moon_phase=4.
   - Pixel (45,80) -> address 158620.
   - Pixel (10,85) -> sky_on=0.
   - Further frame_ticks with isnight held -> phase stays 4.
3. Seven night starts (isnight toggled, each edge sampled on frame_tick) -> phases 4,5,6,3,2,1,0.
4. Star 0 with g=0, pixel (101,21) -> address 224411+18+1 = 224430, star_id=0.
   - Pixel (100,37) -> miss (17 rows).
   - After 10 frame_ticks (g=1): (101,21) -> 224717+19 = 224736, and (100,37) hits.
5. isnight=0, pixel (10,85) -> sky_on=0, address=0.
   - Reset asserted mid-frame -> all outputs 0 the next cycle.
6. Simultaneous frame_tick and pixel (10,85) on the night-start edge -> response uses phase 0 (address 143025). The following cycle at (45,80) uses phase 4.
